// File: rtl/arb_pkg.sv
// arb_pkg: state and grant-id encodings shared by the arbiter and its benches
package arb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, G1 = 2'd1, G2 = 2'd2, G3 = 2'd3} state_t;
  localparam logic [1:0] GNT_NONE = 2'd0;
  localparam logic [1:0] GNT_1 = 2'd1;
  localparam logic [1:0] GNT_2 = 2'd2;
  localparam logic [1:0] GNT_3 = 2'd3;
  localparam logic [1:0] LAST_RESET = GNT_3;
endpackage

// File: rtl/rr_pick.sv
// rr_pick: first requester at or after last+1, wrapping 3->1; 0 when none
module rr_pick
  import arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] last,
  output logic [1:0] next
);
  logic [1:0] c0, c1, c2;
  // Build the three-entry search order, then take the first requester in it
  always_comb begin
    c0 = last == GNT_1 ? GNT_2 : last == GNT_2 ? GNT_3 : GNT_1;
    c1 = c0 == GNT_3 ? GNT_1 : c0 + 2'd1;
    c2 = c1 == GNT_3 ? GNT_1 : c1 + 2'd1;
    next = req[c0 - 2'd1] ? c0 : req[c1 - 2'd1] ? c1 : req[c2 - 2'd1] ? c2 : GNT_NONE;
  end
endmodule

// File: rtl/rr_hold_arbiter.sv
// rr_hold_arbiter: 3-way round-robin arbiter with bounded hold under contention
module rr_hold_arbiter
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       r1,
  input  logic       r2,
  input  logic       r3,
  output logic       a1,
  output logic       a2,
  output logic       a3,
  output logic [1:0] gnt_id,
  output logic       busy
);
  state_t state, nxt;
  logic [3:0] hold_cnt;
  logic [1:0] last, pick;
  logic [2:0] req, mask;
  assign req = {r3, r2, r1};
  assign mask = {state == G3, state == G2, state == G1};
  rr_pick u_pick (.req(req & ~mask), .last(last), .next(pick));
  // Keep the grant while its request holds, unless saturated and someone else waits
  always_comb
    nxt = (|(req & mask) && !(hold_cnt == 4'(MAX_HOLD) && pick != GNT_NONE)) ? state : state_t'(pick);
  // State, hold counter and last-granted index; reset makes r1 first in line
  always_ff @(posedge clk or posedge rstn)
    if (rstn) begin
      state <= IDLE;
      hold_cnt <= 4'd0;
      last <= LAST_RESET;
    end else begin
      state <= nxt;
      if (nxt != state && nxt != IDLE) begin
        hold_cnt <= 4'd1;
        last <= nxt;
      end else if (nxt == IDLE)
        hold_cnt <= 4'd0;
      else if (hold_cnt != 4'(MAX_HOLD))
        hold_cnt <= hold_cnt + 4'd1;
    end
  assign a1 = state == G1;
  assign a2 = state == G2;
  assign a3 = state == G3;
  assign gnt_id = state;
  assign busy = state != IDLE;
endmodule

// File: tb/tb_rr_hold_arbiter.sv
// tb_rr_hold_arbiter: directed and random checks against a behavioural arbiter model
module tb_rr_hold_arbiter;
  localparam int MH = 4;
  logic clk = 0, rstn = 1, r1 = 0, r2 = 0, r3 = 0;
  logic a1, a2, a3, busy;
  logic [1:0] gnt_id;
  int n_cmp = 0, n_bad = 0;
  int cur = 0, cnt = 0, last = 3;

  rr_hold_arbiter #(.MAX_HOLD(MH)) dut (
    .clk(clk), .rstn(rstn), .r1(r1), .r2(r2), .r3(r3),
    .a1(a1), .a2(a2), .a3(a3), .gnt_id(gnt_id), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int rr(input logic [2:0] r, input int excl);
    int i;
    for (int k = 1; k <= 3; k++) begin
      i = (last + k - 1) % 3 + 1;
      if (r[i-1] && i != excl) return i;
    end
    return 0;
  endfunction

  task automatic model(input logic [2:0] r);
    int g;
    if (cur != 0 && r[cur-1] && !(cnt >= MH && rr(r, cur) != 0)) begin
      cnt = cnt < MH ? cnt + 1 : MH;
      return;
    end
    g = rr(r, cur);
    cur = g;
    cnt = g != 0 ? 1 : 0;
    if (g != 0) last = g;
  endtask

  task automatic compare();
    chk("grant", {a3, a2, a1}, cur == 0 ? 0 : 1 << (cur - 1));
    chk("gnt_id", gnt_id, cur);
    chk("busy", busy, cur != 0);
    chk("hold", dut.hold_cnt, cnt);
    chk("onehot0", $onehot0({a3, a2, a1}), 1);
    chk("id_vs_grant", gnt_id, a1 ? 1 : a2 ? 2 : a3 ? 3 : 0);
  endtask

  task automatic cyc(input logic [2:0] r);
    {r3, r2, r1} = r;
    @(posedge clk);
    model(r);
    #1 compare();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1;
    #1;
    cur = 0; cnt = 0; last = 3;
    chk("rst_async_grant", {a3, a2, a1}, 0);
    compare();
    @(posedge clk);
    #1 compare();
    rstn = 0;
  endtask

  initial begin
    do_reset();
    repeat (3) cyc(3'b001);
    repeat (2) cyc(3'b000);
    do_reset();
    repeat (17) cyc(3'b111);
    cyc(3'b000);
    repeat (10) cyc(3'b010);
    chk("hold_saturated", dut.hold_cnt, 4);
    cyc(3'b000);
    repeat (2) cyc(3'b001);
    cyc(3'b100);
    chk("no_bubble_a3", gnt_id, 3);
    cyc(3'b011);
    chk("wrap_to_a1", gnt_id, 1);
    cyc(3'b000);
    repeat (2) cyc(3'b010);
    do_reset();
    cyc(3'b011);
    chk("first_after_reset", gnt_id, 1);
    cyc(3'b000);
    repeat (3000) begin
      logic [2:0] r;
      r = {r3, r2, r1};
      for (int i = 0; i < 3; i++)
        if (r[i]) begin
          if (cur == i + 1 && $urandom_range(3) == 0) r[i] = 0;
          else if ($urandom_range(15) == 0) r[i] = 0;
        end else if ($urandom_range(2) == 0) r[i] = 1;
      if ($urandom_range(199) == 0) do_reset();
      else cyc(r);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
